distributor: RTL and testbench
==============================

Name: distributor

Overview:
- Stream demultiplexer: the counterpart of the two-input stream collector.
- Takes one valid/ready stream carrying a select bit and a packed payload. Routes each token to one of two output streams, chosen by the select bit.
- Each output branch has its own one-entry output register, so a stall on one branch does not block tokens bound for the other.
- Sits wherever a collected (tagged) stream must be split back into per-source streams.

Parameters:
- WIDTH0, 4, payload width of branch 0.
- WIDTH1, 4, payload width of branch 1.
- BURST, "no", "yes" lets a full branch register accept a new token in the same cycle it is drained (full throughput); "no" accepts only into an empty register (at most 1 token per 2 cycles per branch).

Ports:
- iCLK  in  1  clock; all state on rising edge.
- iRST  in  1  synchronous, active-high reset.
- iValid_AM  in  1  input token valid.
- oReady_AM  out  1  input ready.
- iSelect_AM  in  1  destination: 0 = branch 0, 1 = branch 1.
- iData_AM  in  WIDTH0+WIDTH1  packed payload; [WIDTH0-1:0] goes to branch 0, [WIDTH0+WIDTH1-1:WIDTH0] goes to branch 1.
- oValid_BM0  out  1  branch 0 valid.
- iReady_BM0  in  1  branch 0 ready.
- oData_BM0  out  WIDTH0  branch 0 payload.
- oValid_BM1  out  1  branch 1 valid.
- iReady_BM1  in  1  branch 1 ready.
- oData_BM1  out  WIDTH1  branch 1 payload.

Behaviour:
- Reset (iRST=1 at a clock edge):
  - oValid_BM0 = oValid_BM1 = 0.
  - oData_BM0 and oData_BM1 = 0.
  - oReady_AM is forced to 0 for as long as iRST is high.
  - A reset mid-operation discards any held tokens.
- Per-branch state: one flag, EMPTY/FULL, equal to oValid_BMx, plus a data register.
- Branch can-accept signal canX:
  - BURST="no": canX = !oValid_BMx.
  - BURST="yes": canX = !oValid_BMx | iReady_BMx.
- oReady_AM = !iRST & (iSelect_AM ? can1 : can0). This is combinational from iSelect_AM, branch state and, when BURST="yes", iReady_BMx.
- Input transfer: iValid_AM & oReady_AM. On transfer, the selected branch register loads its payload slice and goes FULL at the next edge. The unselected branch is unaffected.
- Output transfer on branch X: oValid_BMx & iReady_BMx.
  - FULL -> EMPTY when the branch drains with no new load.
  - FULL stays FULL with new data when the branch drains and loads in the same cycle (BURST="yes" only).
- Latency: 1 cycle from input transfer to oValid_BMx.
- Output stability: oData_BMx and oValid_BMx are held constant while oValid_BMx=1 and iReady_BMx=0.
- Branches are independent:
  - Both branches may present and drain in the same cycle.
  - A stalled branch blocks only input tokens selected to it.
- The unused payload slice of an input token is discarded.
- Only register outputs drive oValid/oData; there is no combinational path from input to output.

Optional Feature:
- Macro: DISTRIBUTOR_STRICT_ORDER_EN.
- Defined:
  - A token is accepted only if the other branch is EMPTY, i.e. oReady_AM additionally requires !oValid of the non-selected branch.
  - The other branch draining in the same cycle does not count as EMPTY.
  - Guarantees tokens leave in global input order; costs throughput when the branches alternate.
- Undefined: branches are fully independent, as above.

Test Plan:
- Reset: hold iRST=1 for 2 cycles with iValid_AM=1 -> oReady_AM=0, both oValid=0, both oData=0; after release, oReady_AM=1 for either select.
- Single routing, iReady_BM0=iReady_BM1=1:
  - Select=0, data 8'h3a -> next cycle oValid_BM0=1, oData_BM0=4'ha for one cycle.
  - Select=1, data 8'hb0 -> oValid_BM1=1, oData_BM1=4'hb for one cycle.
- Backpressure isolation, iReady_BM0=0, iReady_BM1=1:
  - Send select=0 data 8'h07 -> branch 0 holds 4'h7 stably.
  - A second select=0 token sees oReady_AM=0.
  - Select=1 data 8'h80 is accepted; oData_BM1=4'h8 appears while branch 0 still holds 4'h7.
  - Raising iReady_BM0 drains 4'h7.
- Throughput, all readies 1, four consecutive select=0 tokens 1,2,3,4:
  - BURST="yes": accepted back-to-back, output 1,2,3,4 on consecutive cycles.
  - BURST="no": oReady_AM alternates 1/0; outputs appear every other cycle.
- Simultaneous drain: both branches FULL (4'h1 on branch 0, 4'h2 on branch 1), both readies raised in the same cycle -> both transfer; both oValid=0 next cycle.
- With DISTRIBUTOR_STRICT_ORDER_EN: branch 1 FULL holding 4'h5 with iReady_BM1=0; offer select=0 data 8'h04 -> oReady_AM=0 until branch 1 drains, then 4'h4 is accepted.

Source files
------------

// File: rtl/distributor.sv
// Stream demultiplexer: routes each tagged input token to one of two output
// branches, each with its own one-entry register. Optional DISTRIBUTOR_STRICT_ORDER_EN.
module distributor #(
    parameter int    WIDTH0 = 4,
    parameter int    WIDTH1 = 4,
    parameter string BURST  = "no"
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iValid_AM,
    output logic                     oReady_AM,
    input  logic                     iSelect_AM,
    input  logic [WIDTH0+WIDTH1-1:0] iData_AM,
    output logic                     oValid_BM0,
    input  logic                     iReady_BM0,
    output logic [WIDTH0-1:0]        oData_BM0,
    output logic                     oValid_BM1,
    input  logic                     iReady_BM1,
    output logic [WIDTH1-1:0]        oData_BM1
);

    localparam bit BURST_EN = (BURST == "yes");

    logic              valid0_q, valid0_d;
    logic              valid1_q, valid1_d;
    logic [WIDTH0-1:0] data0_q, data0_d;
    logic [WIDTH1-1:0] data1_q, data1_d;

    logic can0, can1;
    logic other_empty0, other_empty1;
    logic xfer_in, load0, load1, drain0, drain1;

    // A full register may take a new token only if it is draining this cycle.
    always_comb begin
        can0 = !valid0_q | (BURST_EN & iReady_BM0);
        can1 = !valid1_q | (BURST_EN & iReady_BM1);
    end

    // Strict ordering looks at the registered flag only; a same-cycle drain
    // of the other branch does not make it count as empty.
`ifdef DISTRIBUTOR_STRICT_ORDER_EN
    always_comb begin
        other_empty0 = !valid1_q;
        other_empty1 = !valid0_q;
    end
`else
    always_comb begin
        other_empty0 = 1'b1;
        other_empty1 = 1'b1;
    end
`endif

    always_comb begin
        oReady_AM = !iRST & (iSelect_AM ? (can1 & other_empty1)
                                        : (can0 & other_empty0));
        xfer_in   = iValid_AM & oReady_AM;
        load0     = xfer_in & !iSelect_AM;
        load1     = xfer_in & iSelect_AM;
        drain0    = valid0_q & iReady_BM0;
        drain1    = valid1_q & iReady_BM1;
    end

    always_comb begin
        valid0_d = valid0_q;
        data0_d  = data0_q;
        if (load0) begin
            valid0_d = 1'b1;
            data0_d  = iData_AM[WIDTH0-1:0];
        end else if (drain0) begin
            valid0_d = 1'b0;
        end
    end

    always_comb begin
        valid1_d = valid1_q;
        data1_d  = data1_q;
        if (load1) begin
            valid1_d = 1'b1;
            data1_d  = iData_AM[WIDTH0+WIDTH1-1:WIDTH0];
        end else if (drain1) begin
            valid1_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
        end else begin
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
        end
    end

    always_comb begin
        oValid_BM0 = valid0_q;
        oData_BM0  = data0_q;
        oValid_BM1 = valid1_q;
        oData_BM1  = data1_q;
    end

endmodule

// File: tb/tb_distributor.sv
// Directed bench for distributor: one instance with BURST="no" for routing,
// backpressure and ordering, one with BURST="yes" for full-throughput behaviour.
module tb_distributor;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;

    logic       v_n = 1'b0, s_n = 1'b0, r0_n = 1'b1, r1_n = 1'b1;
    logic [7:0] d_n = 8'h00;
    logic       rdy_n, ov0_n, ov1_n;
    logic [3:0] od0_n, od1_n;

    logic       v_y = 1'b0, s_y = 1'b0, r0_y = 1'b1, r1_y = 1'b1;
    logic [7:0] d_y = 8'h00;
    logic       rdy_y, ov0_y, ov1_y;
    logic [3:0] od0_y, od1_y;

    int n_checks = 0;
    int n_errors = 0;

    always #5 iCLK = ~iCLK;

    distributor #(.WIDTH0(4), .WIDTH1(4), .BURST("no")) dut_n (
        .iCLK(iCLK), .iRST(iRST),
        .iValid_AM(v_n), .oReady_AM(rdy_n), .iSelect_AM(s_n), .iData_AM(d_n),
        .oValid_BM0(ov0_n), .iReady_BM0(r0_n), .oData_BM0(od0_n),
        .oValid_BM1(ov1_n), .iReady_BM1(r1_n), .oData_BM1(od1_n)
    );

    distributor #(.WIDTH0(4), .WIDTH1(4), .BURST("yes")) dut_y (
        .iCLK(iCLK), .iRST(iRST),
        .iValid_AM(v_y), .oReady_AM(rdy_y), .iSelect_AM(s_y), .iData_AM(d_y),
        .oValid_BM0(ov0_y), .iReady_BM0(r0_y), .oData_BM0(od0_y),
        .oValid_BM1(ov1_y), .iReady_BM1(r1_y), .oData_BM1(od1_y)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a valid token on offer
        v_n = 1'b1; v_y = 1'b1; d_n = 8'hff; d_y = 8'hff;
        tick(); tick();
        check("rst_ready_n", rdy_n, 0);
        check("rst_ready_y", rdy_y, 0);
        check("rst_ov0", ov0_n, 0);
        check("rst_ov1", ov1_n, 0);
        check("rst_od0", od0_n, 0);
        check("rst_od1", od1_n, 0);
        iRST = 1'b0; v_n = 1'b0; v_y = 1'b0;
        #1 check("post_rst_ready_s0", rdy_n, 1);
        s_n = 1'b1;
        #1 check("post_rst_ready_s1", rdy_n, 1);

        // Single routing to branch 0 then branch 1
        v_n = 1'b1; s_n = 1'b0; d_n = 8'h3a;
        tick(); v_n = 1'b0;
        check("route0_valid", ov0_n, 1);
        check("route0_data", od0_n, 4'ha);
        check("route0_other", ov1_n, 0);
        tick();
        check("route0_drained", ov0_n, 0);
        v_n = 1'b1; s_n = 1'b1; d_n = 8'hb0;
        tick(); v_n = 1'b0;
        check("route1_valid", ov1_n, 1);
        check("route1_data", od1_n, 4'hb);
        check("route1_other", ov0_n, 0);
        tick();
        check("route1_drained", ov1_n, 0);

        // Backpressure on branch 0
        r0_n = 1'b0; r1_n = 1'b1;
        v_n = 1'b1; s_n = 1'b0; d_n = 8'h07;
        tick();
        d_n = 8'h09;
        #1 check("bp_second_ready", rdy_n, 0);
        tick();
        check("bp_hold_valid", ov0_n, 1);
        check("bp_hold_data", od0_n, 4'h7);
        s_n = 1'b1; d_n = 8'h80;
`ifdef DISTRIBUTOR_STRICT_ORDER_EN
        #1 check("bp_strict_other_ready", rdy_n, 0);
        v_n = 1'b0;
        tick();
`else
        #1 check("bp_other_ready", rdy_n, 1);
        tick(); v_n = 1'b0;
        check("bp_other_valid", ov1_n, 1);
        check("bp_other_data", od1_n, 4'h8);
        check("bp_still_data", od0_n, 4'h7);
        tick();
        check("bp_other_drained", ov1_n, 0);
        check("bp_still_valid", ov0_n, 1);
`endif
        r0_n = 1'b1;
        tick();
        check("bp_release", ov0_n, 0);

`ifdef DISTRIBUTOR_STRICT_ORDER_EN
        // Branch 1 holds 5; a branch 0 token waits until branch 1 is empty
        r1_n = 1'b0;
        v_n = 1'b1; s_n = 1'b1; d_n = 8'h50;
        tick();
        check("strict_b1_data", od1_n, 4'h5);
        s_n = 1'b0; d_n = 8'h04;
        #1 check("strict_blocked", rdy_n, 0);
        tick();
        check("strict_b0_empty", ov0_n, 0);
        r1_n = 1'b1;
        #1 check("strict_drain_not_empty", rdy_n, 0);
        tick();
        check("strict_b1_drained", ov1_n, 0);
        check("strict_ready", rdy_n, 1);
        tick(); v_n = 1'b0;
        check("strict_accept_valid", ov0_n, 1);
        check("strict_accept_data", od0_n, 4'h4);
        tick();
`else
        // Both branches full, drained together
        r0_n = 1'b0; r1_n = 1'b0;
        v_n = 1'b1; s_n = 1'b0; d_n = 8'h01;
        tick();
        s_n = 1'b1; d_n = 8'h20;
        tick(); v_n = 1'b0;
        check("sim_full0", ov0_n, 1);
        check("sim_full1", ov1_n, 1);
        check("sim_data0", od0_n, 4'h1);
        check("sim_data1", od1_n, 4'h2);
        r0_n = 1'b1; r1_n = 1'b1;
        tick();
        check("sim_empty0", ov0_n, 0);
        check("sim_empty1", ov1_n, 0);
`endif

        // BURST="no": four tokens, one accepted every other cycle
        r0_n = 1'b1; r1_n = 1'b1; s_n = 1'b0; v_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            d_n = 8'((c / 2) + 1);
            #1;
            check($sformatf("nob_ready_%0d", c), rdy_n, (c % 2 == 0) ? 1 : 0);
            check($sformatf("nob_valid_%0d", c), ov0_n, (c % 2 == 1) ? 1 : 0);
            if (c % 2 == 1)
                check($sformatf("nob_data_%0d", c), od0_n, (c + 1) / 2);
            tick();
        end
        v_n = 1'b0;

        // BURST="yes": tokens 1..4 back-to-back
        r0_y = 1'b1; s_y = 1'b0;
        for (int c = 0; c < 6; c++) begin
            v_y = (c < 4);
            d_y = 8'(c + 1);
            #1;
            check($sformatf("burst_ready_%0d", c), rdy_y, 1);
            check($sformatf("burst_valid_%0d", c), ov0_y, (c > 0 && c < 5) ? 1 : 0);
            if (c > 0 && c < 5)
                check($sformatf("burst_data_%0d", c), od0_y, c);
            tick();
        end

        // BURST="yes": full and stalled branch refuses, ready follows iReady_BM0
        r0_y = 1'b0; v_y = 1'b1; d_y = 8'h0c;
        tick();
        d_y = 8'h0d;
        #1 check("burst_stall_ready", rdy_y, 0);
        s_y = 1'b1;
        #1 check("burst_stall_other", rdy_y, 1);
        s_y = 1'b0; r0_y = 1'b1;
        #1 check("burst_unstall_ready", rdy_y, 1);
        tick(); v_y = 1'b0;
        check("burst_replace_data", od0_y, 4'hd);
        check("burst_replace_valid", ov0_y, 1);
        tick();
        check("burst_final_empty", ov0_y, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
